// File: rtl/audio_io_bridge.sv
// NCH-channel ADC->CPU and CPU->DAC sample bridge built from two pointer-based FIFOs.
// Optional build macro AUDIO_IO_BRIDGE_SATURATE_EN clamps CPU samples instead of truncating them.
module audio_io_bridge #(
   parameter int DWIDTH = 32,
   parameter int SWIDTH = 24,
   parameter int NCH    = 2,
   parameter int DEPTH  = 8,
   localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_adc_valid,
   output logic              o_adc_ready,
   input  logic [SWIDTH-1:0] i_adc_data,
   input  logic [CW-1:0]     i_adc_ch,
   input  logic              i_cpu_rd,
   output logic [DWIDTH-1:0] o_cpu_rdata,
   output logic [CW-1:0]     o_cpu_rd_ch,
   input  logic              i_cpu_wr,
   input  logic [DWIDTH-1:0] i_cpu_wdata,
   output logic              o_dac_valid,
   input  logic              i_dac_ready,
   output logic [SWIDTH-1:0] o_dac_data,
   output logic [CW-1:0]     o_dac_ch,
   output logic [LW-1:0]     o_in_level,
   output logic [LW-1:0]     o_out_level,
   input  logic              i_stat_clr,
   output logic              o_underrun,
   output logic              o_overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = CW + SWIDTH;
   localparam logic [PW-1:0] PTR_WRAP = {1'b1, {AW{1'b0}}};

   logic [EW-1:0]     r_in_mem  [DEPTH];
   logic [EW-1:0]     r_out_mem [DEPTH];
   logic [PW-1:0]     r_in_wr_ptr, r_in_rd_ptr, r_out_wr_ptr, r_out_rd_ptr;
   logic [SWIDTH-1:0] r_last_data;
   logic [CW-1:0]     r_last_ch;
   logic [CW-1:0]     r_wr_ch;
   logic              r_underrun, r_overrun;

   logic              w_in_empty, w_in_full, w_out_empty, w_out_full;
   logic              w_in_push, w_in_pop, w_out_push, w_out_pop, w_adc_lost;
   logic [EW-1:0]     w_in_head, w_out_head;
   logic [SWIDTH-1:0] w_rd_sample, w_wsample;

   assign w_in_empty  = (r_in_wr_ptr == r_in_rd_ptr);
   assign w_in_full   = (r_in_wr_ptr == (r_in_rd_ptr ^ PTR_WRAP));
   assign w_out_empty = (r_out_wr_ptr == r_out_rd_ptr);
   assign w_out_full  = (r_out_wr_ptr == (r_out_rd_ptr ^ PTR_WRAP));

   // A same-cycle CPU read frees a slot, so a full input FIFO can still accept.
   assign o_adc_ready = !i_reset && (!w_in_full || i_cpu_rd);
   assign w_in_push   = i_adc_valid && o_adc_ready;
   assign w_in_pop    = i_cpu_rd && !w_in_empty;
   assign w_adc_lost  = i_adc_valid && !o_adc_ready && !i_reset;
   assign w_out_push  = i_cpu_wr && !w_out_full;
   assign w_out_pop   = !w_out_empty && i_dac_ready;

   assign w_in_head   = r_in_mem[r_in_rd_ptr[AW-1:0]];
   assign w_out_head  = r_out_mem[r_out_rd_ptr[AW-1:0]];
   assign w_rd_sample = w_in_empty ? r_last_data : w_in_head[SWIDTH-1:0];
   assign o_cpu_rdata = DWIDTH'($signed(w_rd_sample));
   assign o_cpu_rd_ch = w_in_empty ? r_last_ch : w_in_head[EW-1:SWIDTH];

   assign o_dac_valid = !w_out_empty;
   assign o_dac_data  = w_out_empty ? {SWIDTH{1'b0}} : w_out_head[SWIDTH-1:0];
   assign o_dac_ch    = w_out_empty ? {CW{1'b0}} : w_out_head[EW-1:SWIDTH];

   assign o_in_level  = LW'(r_in_wr_ptr - r_in_rd_ptr);
   assign o_out_level = LW'(r_out_wr_ptr - r_out_rd_ptr);
   assign o_underrun  = r_underrun;
   assign o_overrun   = r_overrun;

`ifdef AUDIO_IO_BRIDGE_SATURATE_EN
   logic [DWIDTH-SWIDTH:0] w_wdata_hi;
   assign w_wdata_hi = i_cpu_wdata[DWIDTH-1:SWIDTH-1];

   // Clamp to the signed SWIDTH range when the discarded bits are not a sign extension.
   always_comb begin
      w_wsample = i_cpu_wdata[SWIDTH-1:0];
      if ((w_wdata_hi == {(DWIDTH-SWIDTH+1){1'b0}}) || (w_wdata_hi == {(DWIDTH-SWIDTH+1){1'b1}})) begin
         w_wsample = i_cpu_wdata[SWIDTH-1:0];
      end else if (i_cpu_wdata[DWIDTH-1]) begin
         w_wsample = {1'b1, {(SWIDTH-1){1'b0}}};
      end else begin
         w_wsample = {1'b0, {(SWIDTH-1){1'b1}}};
      end
   end
`else
   logic w_unused_wdata_hi;
   assign w_unused_wdata_hi = &{1'b0, i_cpu_wdata[DWIDTH-1:SWIDTH-1]};
   assign w_wsample = i_cpu_wdata[SWIDTH-1:0];
`endif

   // Sample storage for both FIFOs; contents are only visible through the pointers.
   always_ff @(posedge i_clock) begin
      if (w_in_push) begin
         r_in_mem[r_in_wr_ptr[AW-1:0]] <= {i_adc_ch, i_adc_data};
      end
      if (w_out_push) begin
         r_out_mem[r_out_wr_ptr[AW-1:0]] <= {r_wr_ch, w_wsample};
      end
   end

   // Input FIFO pointers and the last-popped sample shown while empty.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_in_wr_ptr <= {PW{1'b0}};
         r_in_rd_ptr <= {PW{1'b0}};
         r_last_data <= {SWIDTH{1'b0}};
         r_last_ch   <= {CW{1'b0}};
      end else begin
         if (w_in_push) r_in_wr_ptr <= r_in_wr_ptr + PW'(1);
         if (w_in_pop) begin
            r_in_rd_ptr <= r_in_rd_ptr + PW'(1);
            r_last_data <= w_in_head[SWIDTH-1:0];
            r_last_ch   <= w_in_head[EW-1:SWIDTH];
         end
      end
   end

   // Output FIFO pointers and the round-robin write-channel counter.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_out_wr_ptr <= {PW{1'b0}};
         r_out_rd_ptr <= {PW{1'b0}};
         r_wr_ch      <= {CW{1'b0}};
      end else begin
         if (w_out_push) begin
            r_out_wr_ptr <= r_out_wr_ptr + PW'(1);
            r_wr_ch      <= (r_wr_ch == CW'(NCH - 1)) ? {CW{1'b0}} : r_wr_ch + CW'(1);
         end
         if (w_out_pop) r_out_rd_ptr <= r_out_rd_ptr + PW'(1);
      end
   end

   // Sticky error flags; a new event wins over a simultaneous clear.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_underrun <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (i_cpu_rd && w_in_empty) r_underrun <= 1'b1;
         else if (i_stat_clr)        r_underrun <= 1'b0;
         if ((i_cpu_wr && w_out_full) || w_adc_lost) r_overrun <= 1'b1;
         else if (i_stat_clr)                        r_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_audio_io_bridge.sv
// Directed bench for audio_io_bridge (default parameters); expectations follow the
// AUDIO_IO_BRIDGE_SATURATE_EN setting of the build.
module tb_audio_io_bridge;

   logic        clk = 1'b0;
   logic        reset, adc_valid, adc_ready, cpu_rd, cpu_wr;
   logic [23:0] adc_data, dac_data;
   logic [0:0]  adc_ch, cpu_rd_ch, dac_ch;
   logic [31:0] cpu_rdata, cpu_wdata;
   logic        dac_valid, dac_ready, stat_clr, underrun, overrun;
   logic [3:0]  in_level, out_level;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   audio_io_bridge dut (
      .i_clock(clk), .i_reset(reset),
      .i_adc_valid(adc_valid), .o_adc_ready(adc_ready), .i_adc_data(adc_data), .i_adc_ch(adc_ch),
      .i_cpu_rd(cpu_rd), .o_cpu_rdata(cpu_rdata), .o_cpu_rd_ch(cpu_rd_ch),
      .i_cpu_wr(cpu_wr), .i_cpu_wdata(cpu_wdata),
      .o_dac_valid(dac_valid), .i_dac_ready(dac_ready), .o_dac_data(dac_data), .o_dac_ch(dac_ch),
      .o_in_level(in_level), .o_out_level(out_level),
      .i_stat_clr(stat_clr), .o_underrun(underrun), .o_overrun(overrun)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

`ifdef AUDIO_IO_BRIDGE_SATURATE_EN
   localparam logic [31:0] SAT_POS = 32'h007FFFFF;
   localparam logic [31:0] SAT_NEG = 32'h00800000;
`else
   localparam logic [31:0] SAT_POS = 32'h00000000;
   localparam logic [31:0] SAT_NEG = 32'h00000000;
`endif

   initial begin
      reset = 1'b1; adc_valid = 1'b0; adc_data = 24'h0; adc_ch = 1'b0;
      cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 32'h0; dac_ready = 1'b0; stat_clr = 1'b0;
      tick(); tick();
      check("adc_ready_in_reset", 32'(adc_ready), 32'd0);
      reset = 1'b0; #1;
      check("rst_adc_ready", 32'(adc_ready), 32'd1);
      check("rst_in_level", 32'(in_level), 32'd0);
      check("rst_out_level", 32'(out_level), 32'd0);
      check("rst_dac_valid", 32'(dac_valid), 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'h0);
      check("rst_dac_data", 32'(dac_data), 32'h0);
      check("rst_flags", 32'({underrun, overrun}), 32'd0);

      // First ADC sample appears one cycle later, sign-extended
      adc_valid = 1'b1; adc_data = 24'h800001; adc_ch = 1'b1;
      tick(); adc_valid = 1'b0;
      check("fwft_rdata", cpu_rdata, 32'hFF800001);
      check("fwft_rd_ch", 32'(cpu_rd_ch), 32'd1);
      check("fwft_level", 32'(in_level), 32'd1);

      // Fill to 8, then push with simultaneous read
      for (int i = 1; i < 8; i++) begin
         adc_valid = 1'b1; adc_data = 24'(i); adc_ch = 1'(i);
         tick();
      end
      adc_valid = 1'b0; #1;
      check("full_level", 32'(in_level), 32'd8);
      check("full_adc_ready", 32'(adc_ready), 32'd0);
      adc_valid = 1'b1; adc_data = 24'h000123; adc_ch = 1'b0; cpu_rd = 1'b1; #1;
      check("full_rd_frees_slot", 32'(adc_ready), 32'd1);
      tick(); adc_valid = 1'b0;
      check("full_pushpop_level", 32'(in_level), 32'd8);
      check("full_pushpop_head", cpu_rdata, 32'h00000001);
      check("full_pushpop_ch", 32'(cpu_rd_ch), 32'd1);
      repeat (8) tick();
      cpu_rd = 1'b0; #1;
      check("drain_level", 32'(in_level), 32'd0);
      check("drain_last", cpu_rdata, 32'h00000123);
      check("drain_no_flags", 32'({underrun, overrun}), 32'd0);

      // Underrun on empty, clear, and set-over-clear priority
      cpu_rd = 1'b1; tick(); cpu_rd = 1'b0;
      check("underrun_hold", cpu_rdata, 32'h00000123);
      check("underrun_set", 32'(underrun), 32'd1);
      stat_clr = 1'b1; tick(); stat_clr = 1'b0;
      check("underrun_clr", 32'(underrun), 32'd0);
      cpu_rd = 1'b1; stat_clr = 1'b1; tick(); cpu_rd = 1'b0; stat_clr = 1'b0;
      check("set_beats_clr", 32'(underrun), 32'd1);

      // Push+pop on empty: push lands, pop is an underrun
      adc_valid = 1'b1; adc_data = 24'h000456; adc_ch = 1'b1; cpu_rd = 1'b1; stat_clr = 1'b1;
      tick(); adc_valid = 1'b0; cpu_rd = 1'b0; stat_clr = 1'b0;
      check("pp_empty_level", 32'(in_level), 32'd1);
      check("pp_empty_underrun", 32'(underrun), 32'd1);
      check("pp_empty_rdata", cpu_rdata, 32'h00000456);
      cpu_rd = 1'b1; stat_clr = 1'b1; tick(); cpu_rd = 1'b0; stat_clr = 1'b0;
      check("pp_pop_level", 32'(in_level), 32'd0);
      check("pp_clr_underrun", 32'(underrun), 32'd0);

      // Output FIFO: 9 writes with DAC stalled
      for (int k = 0; k < 9; k++) begin
         cpu_wr = 1'b1; cpu_wdata = 32'(16 + k);
         tick();
         if (k == 0) check("out_latency", 32'(dac_valid), 32'd1);
      end
      cpu_wr = 1'b0; #1;
      check("out_full_level", 32'(out_level), 32'd8);
      check("out_overrun", 32'(overrun), 32'd1);
      check("out_stall_data", 32'(dac_data), 32'h10);
      stat_clr = 1'b1; tick(); stat_clr = 1'b0;
      check("overrun_clr", 32'(overrun), 32'd0);
      dac_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check("drain_dac_data", 32'(dac_data), 32'(16 + k));
         check("drain_dac_ch", 32'(dac_ch), 32'(k % 2));
         tick();
      end
      check("out_empty_valid", 32'(dac_valid), 32'd0);
      check("out_empty_data", 32'(dac_data), 32'h0);

      // Dropped 9th write must not have advanced the channel counter
      cpu_wr = 1'b1; cpu_wdata = 32'hFFFFFF80; tick(); cpu_wr = 1'b0;
      check("wr_ch_not_advanced", 32'(dac_ch), 32'd0);
      check("neg_trunc", 32'(dac_data), 32'h00FFFF80);
      tick();
      check("pop_neg_level", 32'(out_level), 32'd0);

      // No cut-through: a full FIFO rejects a write even when the DAC pops
      dac_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cpu_wr = 1'b1; cpu_wdata = 32'(100 + k); tick();
      end
      cpu_wr = 1'b1; cpu_wdata = 32'h55; dac_ready = 1'b1; tick();
      cpu_wr = 1'b0; dac_ready = 1'b0;
      check("no_cut_level", 32'(out_level), 32'd7);
      check("no_cut_overrun", 32'(overrun), 32'd1);
      check("no_cut_head", 32'(dac_data), 32'd101);
      check("no_cut_ch", 32'(dac_ch), 32'd0);
      dac_ready = 1'b1; stat_clr = 1'b1; repeat (7) tick(); dac_ready = 1'b0; stat_clr = 1'b0;
      check("no_cut_drain", 32'(out_level), 32'd0);

      // Out-of-range CPU samples
      cpu_wr = 1'b1; cpu_wdata = 32'h01000000; tick();
      cpu_wdata = 32'hFE000000; tick(); cpu_wr = 1'b0;
      check("sat_pos", 32'(dac_data), SAT_POS);
      check("sat_pos_ch", 32'(dac_ch), 32'd1);
      dac_ready = 1'b1; tick(); dac_ready = 1'b0;
      check("sat_neg", 32'(dac_data), SAT_NEG);
      check("sat_neg_ch", 32'(dac_ch), 32'd0);
      dac_ready = 1'b1; tick(); dac_ready = 1'b0;

      // Reset with both FIFOs partly full and a flag set
      cpu_rd = 1'b1; tick(); cpu_rd = 1'b0;
      for (int k = 0; k < 4; k++) begin
         adc_valid = 1'b1; adc_data = 24'(k + 40); adc_ch = 1'(k);
         cpu_wr = (k < 2); cpu_wdata = 32'(k + 60);
         tick();
      end
      adc_valid = 1'b0; cpu_wr = 1'b0; #1;
      check("pre_rst_levels", 32'({in_level, out_level}), 32'h42);
      check("pre_rst_underrun", 32'(underrun), 32'd1);
      reset = 1'b1; tick();
      check("mid_rst_levels", 32'({in_level, out_level}), 32'h00);
      check("mid_rst_dac_valid", 32'(dac_valid), 32'd0);
      check("mid_rst_flags", 32'({underrun, overrun}), 32'd0);
      check("mid_rst_rdata", cpu_rdata, 32'h0);
      reset = 1'b0;
      cpu_wr = 1'b1; cpu_wdata = 32'd7; tick(); cpu_wr = 1'b0;
      check("mid_rst_wr_ch", 32'(dac_ch), 32'd0);
      check("mid_rst_new_data", 32'(dac_data), 32'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
